// File: rtl/parity_stream_unit.sv
// Streaming parity generator/checker with frame (column) parity.
// One output register stage on a valid/ready stream.
module parity_stream_unit #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned ODD   = 0,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             mode,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [WIDTH-1:0] s_data,
  input  logic             s_par,
  input  logic             s_last,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data,
  output logic             m_par,
  output logic             m_err,
  output logic             m_last,
  output logic [WIDTH-1:0] m_frame_par,
  output logic [CNT_W-1:0] err_count,
  input  logic             clr_count
);

  typedef enum logic {
    IDLE     = 1'b0,
    IN_FRAME = 1'b1
  } state_t;

  localparam logic             ODD_B   = (ODD != 0);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state_q;
  state_t           state_d;
  logic             mode_q;
  logic             eff_mode;
  logic [WIDTH-1:0] acc_q;
  logic             accept;
  logic             par;
  logic             err;
  logic [WIDTH-1:0] fpar;

  assign s_ready = !m_valid || m_ready;
  assign accept  = s_valid && s_ready;

  // Frame state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Frame state transitions on accepted beats
  always_comb begin
    state_d = state_q;
    if (accept) begin
      if (s_last) begin
        state_d = IDLE;
      end else begin
        state_d = IN_FRAME;
      end
    end
  end

  // Beat results: first beat uses live mode, later beats the latched one
  always_comb begin
    eff_mode = (state_q == IDLE) ? mode : mode_q;
    par      = (^s_data) ^ ODD_B;
    err      = eff_mode && (s_par ^ par);
    fpar     = s_last ? (acc_q ^ s_data) : '0;
  end

  // Mode latch and column parity accumulator
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q <= 1'b0;
      acc_q  <= '0;
    end else if (accept) begin
      if (state_q == IDLE) begin
        mode_q <= mode;
      end
      acc_q <= s_last ? '0 : (acc_q ^ s_data);
    end
  end

  // Output register stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid     <= 1'b0;
      m_data      <= '0;
      m_par       <= 1'b0;
      m_err       <= 1'b0;
      m_last      <= 1'b0;
      m_frame_par <= '0;
    end else if (accept) begin
      m_valid     <= 1'b1;
      m_data      <= s_data;
      m_par       <= par;
      m_err       <= err;
      m_last      <= s_last;
      m_frame_par <= fpar;
    end else if (m_ready) begin
      m_valid <= 1'b0;
    end
  end

  // Saturating error counter; clear wins but still counts a same-cycle error
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_count <= '0;
    end else if (clr_count) begin
      err_count <= (accept && err) ? CNT_ONE : '0;
    end else if (accept && err && (err_count != CNT_MAX)) begin
      err_count <= err_count + CNT_ONE;
    end
  end

endmodule
